// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: shifts in MSB-first bits, aligns on COMMA,
// locks after LOCK_COUNT aligned commas and then emits one byte every 8 clocks.
module serial_paralelo_rx #(
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter logic [7:0]  IDLE       = 8'h7C,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [BYTE_W-1:0]   sr_q, sr_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]    comma_cnt_q, comma_cnt_d;
    logic [BYTE_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                strobe_q, strobe_d;
    logic                active_q, active_d;

    logic [BYTE_W-1:0]   nxt_c;
    logic                boundary_c;
    logic [CNT_W-1:0]    comma_inc_c;

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= SEARCH;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            strobe_q    <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            strobe_q    <= strobe_d;
            active_q    <= active_d;
        end
    end

    // Next-state: candidate byte includes the bit being sampled this cycle.
    always_comb begin
        nxt_c       = {sr_q[BYTE_W-2:0], data_in};
        boundary_c  = (bit_cnt_q == 3'd7);
        comma_inc_c = comma_cnt_q + 4'd1;

        state_d     = state_q;
        sr_d        = nxt_c;
        bit_cnt_d   = bit_cnt_q + 3'd1;
        comma_cnt_d = comma_cnt_q;
        data_d      = data_q;
        valid_d     = valid_q;
        strobe_d    = 1'b0;
        active_d    = active_q;

        case (state_q)
            SEARCH: begin
                bit_cnt_d = bit_cnt_q;
                if (nxt_c == COMMA) begin
                    state_d     = ALIGN;
                    bit_cnt_d   = '0;
                    comma_cnt_d = 4'd1;
                end
            end
            ALIGN: begin
                if (boundary_c) begin
                    if (nxt_c == COMMA) begin
                        comma_cnt_d = comma_inc_c;
                        if (comma_inc_c == LOCK_CNT) begin
                            state_d  = LOCKED;
                            active_d = 1'b1;
                        end
                    end else begin
                        state_d     = SEARCH;
                        comma_cnt_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (boundary_c) begin
                    data_d   = nxt_c;
                    strobe_d = 1'b1;
                    valid_d  = (nxt_c != COMMA) && (nxt_c != IDLE);
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign byte_strobe = strobe_q;
    assign active      = active_q;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Directed + randomized bench for serial_paralelo_rx against an edge-numbered
// reference model built from the alignment/lock rules.
module tb_serial_paralelo_rx;

    localparam logic [7:0]  COMMA      = 8'hBC;
    localparam logic [7:0]  IDLE       = 8'h7C;
    localparam int unsigned LOCK_COUNT = 4;

    logic       clk_32f = 1'b0;
    logic       reset_L;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    int n_pass  = 0;
    int n_total = 0;
    int edge_n  = 0;

    // Reference model state
    logic [7:0] m_win;
    bit         m_aligned, m_locked;
    int         m_anchor, m_cnt;
    logic [7:0] m_data;
    logic       m_valid, m_strobe, m_active;

    serial_paralelo_rx #(
        .COMMA(COMMA), .IDLE(IDLE), .LOCK_COUNT(LOCK_COUNT)
    ) dut (
        .clk_32f(clk_32f), .reset_L(reset_L), .data_in(data_in),
        .data_out(data_out), .valid_out(valid_out),
        .byte_strobe(byte_strobe), .active(active)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s edge=%0d observed=%h expected=%h", tag, edge_n, obs, exp);
    endtask

    task automatic model_reset();
        m_win = '0; m_aligned = 0; m_locked = 0; m_anchor = 0; m_cnt = 0;
        m_data = '0; m_valid = 0; m_strobe = 0; m_active = 0;
    endtask

    // Boundaries are every 8th edge counted from the first comma match.
    task automatic model_step(input logic b, input int n);
        m_win    = {m_win[6:0], b};
        m_strobe = 0;
        if (m_locked) begin
            if ((n - m_anchor) % 8 == 0) begin
                m_data   = m_win;
                m_strobe = 1;
                m_valid  = (m_win != COMMA) && (m_win != IDLE);
            end
        end else if (!m_aligned) begin
            if (m_win == COMMA) begin
                m_aligned = 1; m_anchor = n; m_cnt = 1;
            end
        end else if ((n - m_anchor) % 8 == 0) begin
            if (m_win == COMMA) begin
                m_cnt++;
                if (m_cnt == LOCK_COUNT) begin
                    m_locked = 1; m_active = 1;
                end
            end else begin
                m_aligned = 0; m_cnt = 0;
            end
        end
    endtask

    task automatic check_outputs();
        check("data_out",    data_out,          m_data);
        check("valid_out",   8'(valid_out),     8'(m_valid));
        check("byte_strobe", 8'(byte_strobe),   8'(m_strobe));
        check("active",      8'(active),        8'(m_active));
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
        edge_n++;
        model_step(b, edge_n);
        check_outputs();
        @(negedge clk_32f);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    // Assert reset between edges, verify async clear, release at next negedge.
    task automatic do_reset();
        #2;
        reset_L = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk_32f);
        reset_L = 1'b1;
        edge_n  = 0;
    endtask

    initial begin
        logic [7:0] rb;
        int nj;
        reset_L = 1'b0;
        data_in = 1'b0;
        model_reset();
        @(negedge clk_32f);
        check_outputs();
        reset_L = 1'b1;

        // Random serial data, then reset between edges
        for (int i = 0; i < 20; i++) send_bit(1'($urandom % 2));
        do_reset();

        // Basic lock
        for (int i = 0; i < 4; i++) send_byte(COMMA);
        check("lock_edge32", 8'(active), 8'd1);
        send_byte(8'h55);
        check("first_data", data_out, 8'h55);
        check("first_valid", 8'(valid_out), 8'd1);
        check("first_strobe", 8'(byte_strobe), 8'd1);
        send_byte(8'h3C);
        check("second_data", data_out, 8'h3C);

        // Filler and comma while locked
        send_byte(IDLE);
        check("idle_valid", 8'(valid_out), 8'd0);
        send_byte(COMMA);
        check("comma_data", data_out, COMMA);
        check("comma_valid", 8'(valid_out), 8'd0);
        send_byte(8'hF0);
        check("f0_valid", 8'(valid_out), 8'd1);
        check("still_active", 8'(active), 8'd1);

        // Random payload while locked
        for (int i = 0; i < 16; i++) send_byte(8'($urandom));

        // Reset mid-byte while locked, then re-acquire
        rb = 8'($urandom);
        for (int i = 7; i >= 4; i--) send_bit(rb[i]);
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(COMMA);
        check("relock_active", 8'(active), 8'd1);
        send_byte(8'h42);
        check("relock_data", data_out, 8'h42);

        // Offset alignment
        do_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        for (int i = 0; i < 3; i++) send_byte(COMMA);
        check("offset_prelock", 8'(active), 8'd0);
        send_byte(COMMA);
        check("offset_lock_edge35", 8'(active), 8'd1);
        send_byte(8'hA5);
        check("offset_data", data_out, 8'hA5);
        check("offset_valid", 8'(valid_out), 8'd1);

        // Broken sync
        do_reset();
        for (int i = 0; i < 3; i++) send_byte(COMMA);
        send_byte(8'hA5);
        for (int i = 0; i < 3; i++) send_byte(COMMA);
        check("broken_edge56", 8'(active), 8'd0);
        send_byte(COMMA);
        check("broken_edge64", 8'(active), 8'd1);
        send_byte(8'h11);
        check("broken_data", data_out, 8'h11);

        // Random junk offset, commas, random payload
        do_reset();
        nj = int'($urandom_range(0, 7));
        for (int i = 0; i < nj; i++) send_bit(1'($urandom % 2));
        for (int i = 0; i < 4; i++) send_byte(COMMA);
        for (int i = 0; i < 10; i++) send_byte(8'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
